ad7771_config_sequencer: RTL and testbench

// Power-up/configuration controller for the AD7771. Pulses the ADC /RESET pin, waits out
// the ADC startup time, then writes NUM_REGS 16-bit register frames over the SPI control port.

---
 rtl/ad7771_config_sequencer_if.sv | 25 ++
 rtl/ad7771_config_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_ad7771_config_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad7771_config_sequencer_if.sv
// Pin bundle between the AD7771 configuration sequencer and the ADC control port.
// The master side drives /RESET, /CS, SCLK and SDI of the ADC; the slave side is the ADC.
interface ad7771_config_sequencer_if;
    logic adc_reset_n;
    logic cs_n;
    logic sclk;
    logic sdo;
    logic sdi;

    modport master (
        output adc_reset_n,
        output cs_n,
        output sclk,
        output sdo,
        input  sdi
    );

    modport slave (
        input  adc_reset_n,
        input  cs_n,
        input  sclk,
        input  sdo,
        output sdi
    );
endinterface

// File: rtl/ad7771_config_sequencer.sv
// AD7771 power-up controller: pulses /RESET, waits out ADC startup, writes NUM_REGS SPI
// register frames, then raises readout_en_o to release the DOUT reader.
module ad7771_config_sequencer #(
    parameter int CLK_DIV        = 4,
    parameter int NUM_REGS       = 4,
    parameter int RST_CYCLES     = 100,
    parameter int STARTUP_CYCLES = 25000,
    parameter int CS_GAP         = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [NUM_REGS*16-1:0]   cfg_i,
    output logic [7:0]               rd_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     readout_en_o,
    ad7771_config_sequencer_if.master adc
);

    // The LOAD cycle completes the startup wait, so the first /CS fall lands exactly
    // STARTUP_CYCLES after /RESET release.
    localparam int STARTUP_HOLD = (STARTUP_CYCLES > 1) ? STARTUP_CYCLES - 1 : 1;
    localparam int RST_W        = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int STARTUP_W    = $clog2(STARTUP_CYCLES + 1);
    localparam int GAP_W        = $clog2(CS_GAP + 1);
    localparam int DIV_W        = $clog2(CLK_DIV + 1);
    localparam int HALF_W       = $clog2(34);
    localparam int IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ADC_RST,
        STARTUP,
        LOAD,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [STARTUP_W-1:0] start_cnt_q, start_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [HALF_W-1:0]    half_q, half_d;
    logic [15:0]          frame_q, frame_d;
    logic [7:0]           cap_q, cap_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 adc_reset_n_q, adc_reset_n_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 sdo_q, sdo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 half_wrap;
    logic [3:0]           bit_sel;
    logic [15:0]          frame_sel;

    assign half_wrap = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign bit_sel   = ~half_q[4:1];
    assign frame_sel = cfg_i[int'(idx_q)*16 +: 16];

    // half_q counts SCLK half-periods since t0: odd entries are falls, even entries rises,
    // and entry 33 ends the frame after the trailing hold.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rst_cnt_d   = '0;
        start_cnt_d = '0;
        gap_cnt_d   = '0;
        div_cnt_d   = '0;
        half_d      = '0;
        frame_d     = frame_q;
        cap_d       = cap_q;
        rd_data_d   = rd_data_q;
        sclk_d      = 1'b1;
        sdo_d       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = ADC_RST;
                    idx_d   = '0;
                end
            end
            ADC_RST: begin
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
                    state_d = STARTUP;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            STARTUP: begin
                if (start_cnt_q == STARTUP_W'(STARTUP_HOLD - 1)) begin
                    state_d = LOAD;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            LOAD: begin
                frame_d = frame_sel;
                sdo_d   = frame_sel[15];
                cap_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sclk_d    = sclk_q;
                sdo_d     = sdo_q;
                half_d    = half_q;
                div_cnt_d = div_cnt_q + 1'b1;
                if (half_wrap) begin
                    div_cnt_d = '0;
                    half_d    = half_q + 1'b1;
                    if (half_q == HALF_W'(32)) begin
                        half_d    = '0;
                        sdo_d     = 1'b0;
                        rd_data_d = cap_q;
                        state_d   = GAP;
                    end else if (!half_q[0]) begin
                        sclk_d = 1'b0;
                        sdo_d  = frame_q[bit_sel];
                    end else begin
                        sclk_d = 1'b1;
                        cap_d  = {cap_q[6:0], adc.sdi};
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pin and status levels follow the upcoming state so every output stays registered.
        cs_n_d        = (state_d != SHIFT);
        adc_reset_n_d = (state_d != ADC_RST);
        busy_d        = !((state_d == IDLE) || (state_d == DONE));
        done_d        = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            rst_cnt_q     <= '0;
            start_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            div_cnt_q     <= '0;
            half_q        <= '0;
            frame_q       <= '0;
            cap_q         <= '0;
            rd_data_q     <= '0;
            adc_reset_n_q <= 1'b1;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b1;
            sdo_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            rst_cnt_q     <= rst_cnt_d;
            start_cnt_q   <= start_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            div_cnt_q     <= div_cnt_d;
            half_q        <= half_d;
            frame_q       <= frame_d;
            cap_q         <= cap_d;
            rd_data_q     <= rd_data_d;
            adc_reset_n_q <= adc_reset_n_d;
            cs_n_q        <= cs_n_d;
            sclk_q        <= sclk_d;
            sdo_q         <= sdo_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign adc.adc_reset_n = adc_reset_n_q;
    assign adc.cs_n        = cs_n_q;
    assign adc.sclk        = sclk_q;
    assign adc.sdo         = sdo_q;
    assign rd_data_o       = rd_data_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign readout_en_o    = done_q;

endmodule

// File: tb/tb_ad7771_config_sequencer.sv
// Directed bench for ad7771_config_sequencer: an SPI slave model on the pins records
// every frame and its timing, and scenario tasks compare against hand-computed values.
module tb_ad7771_config_sequencer;

    localparam int CLK_DIV        = 2;
    localparam int NUM_REGS       = 3;
    localparam int RST_CYCLES     = 10;
    localparam int STARTUP_CYCLES = 20;
    localparam int CS_GAP         = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start_i;
    logic [NUM_REGS*16-1:0] cfg_i;
    logic [7:0]             rd_data_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   readout_en_o;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    ad7771_config_sequencer_if ifc ();

    ad7771_config_sequencer #(
        .CLK_DIV        (CLK_DIV),
        .NUM_REGS       (NUM_REGS),
        .RST_CYCLES     (RST_CYCLES),
        .STARTUP_CYCLES (STARTUP_CYCLES),
        .CS_GAP         (CS_GAP)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (start_i),
        .cfg_i        (cfg_i),
        .rd_data_o    (rd_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .readout_en_o (readout_en_o),
        .adc          (ifc.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // SPI slave model: watches pins mid-cycle, drives sdi from sdiWord on each SCLK fall.
    logic [15:0] sdiWord = 16'h0000;
    logic        sdi     = 1'b0;
    assign ifc.sdi = sdi;

    logic        prevCs    = 1'b1;
    logic        prevSclk  = 1'b1;
    logic        prevRstn  = 1'b1;
    logic        prevDone  = 1'b0;
    logic        awaitFirst = 1'b0;
    logic [15:0] rxWord    = 16'h0000;
    int          lowCnt    = 0;
    int          releaseCycle = 0;
    int          fallCycle = 0;
    int          riseCycle = 0;
    int          bitCnt    = 0;
    int          fallCnt   = 0;
    int          violations = 0;
    int          rstLenQ[$];
    int          relToCsQ[$];
    int          csLowQ[$];
    int          gapQ[$];
    int          bitsQ[$];
    int          doneGapQ[$];
    logic [15:0] wordQ[$];

    always @(negedge clk) begin
        if (ifc.adc_reset_n === 1'b0) lowCnt++;
        if (ifc.adc_reset_n === 1'b1 && prevRstn === 1'b0) begin
            rstLenQ.push_back(lowCnt);
            lowCnt = 0;
            releaseCycle = cycle;
            awaitFirst = 1'b1;
        end
        if (ifc.cs_n === 1'b0 && prevCs === 1'b1) begin
            if (ifc.adc_reset_n !== 1'b1) violations++;
            if (awaitFirst) begin
                relToCsQ.push_back(cycle - releaseCycle);
                awaitFirst = 1'b0;
            end
            gapQ.push_back(cycle - riseCycle);
            fallCycle = cycle;
            bitCnt = 0;
            fallCnt = 0;
            rxWord = 16'h0000;
            sdi = sdiWord[15];
        end
        if (ifc.cs_n === 1'b1 && prevCs === 1'b1 && ifc.sclk !== prevSclk) violations++;
        if (ifc.cs_n === 1'b0 && prevCs === 1'b0) begin
            if (ifc.sclk === 1'b1 && prevSclk === 1'b0) begin
                rxWord = {rxWord[14:0], ifc.sdo};
                bitCnt++;
            end
            if (ifc.sclk === 1'b0 && prevSclk === 1'b1) begin
                if (fallCnt < 16) sdi = sdiWord[15 - fallCnt];
                fallCnt++;
            end
        end
        if (ifc.cs_n === 1'b1 && prevCs === 1'b0) begin
            wordQ.push_back(rxWord);
            bitsQ.push_back(bitCnt);
            csLowQ.push_back(cycle - fallCycle);
            riseCycle = cycle;
        end
        if (done_o === 1'b1 && prevDone === 1'b0) doneGapQ.push_back(cycle - riseCycle);
        prevCs   = ifc.cs_n;
        prevSclk = ifc.sclk;
        prevRstn = ifc.adc_reset_n;
        prevDone = done_o;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time=%0t required finish before 100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulseStart();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_o !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: done_o=%b required 1 within %0d cycles", done_o, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        cfg_i = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({ifc.adc_reset_n, ifc.cs_n, ifc.sclk, ifc.sdo} !== 4'b1110) begin
            bad++;
            $display("FAIL reset_pins: {rstn,cs_n,sclk,sdo}=%b required 1110",
                     {ifc.adc_reset_n, ifc.cs_n, ifc.sclk, ifc.sdo});
        end
        total++;
        if ({rd_data_o, busy_o, done_o, readout_en_o} !== 11'h000) begin
            bad++;
            $display("FAIL reset_status: rd=%h busy=%b done=%b ren=%b required 00 0 0 0",
                     rd_data_o, busy_o, done_o, readout_en_o);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({busy_o, ifc.adc_reset_n, ifc.cs_n} !== 3'b011) begin
            bad++;
            $display("FAIL idle_hold: {busy,rstn,cs_n}=%b required 011",
                     {busy_o, ifc.adc_reset_n, ifc.cs_n});
        end
    endtask

    task automatic test_first_sequence();
        int nR = rstLenQ.size();
        int nT = relToCsQ.size();
        int nF = wordQ.size();
        logic [15:0] w;
        cfg_i = {16'h0303, 16'h0202, 16'h0A5C};
        sdiWord = 16'h3CA7;
        pulseStart();
        total++;
        if ({busy_o, ifc.adc_reset_n} !== 2'b10) begin
            bad++;
            $display("FAIL start_entry: {busy,rstn}=%b required 10", {busy_o, ifc.adc_reset_n});
        end
        waitDone(600);
        total++;
        if (rstLenQ.size() != nR + 1 || rstLenQ[nR] != RST_CYCLES) begin
            bad++;
            $display("FAIL rst_len: pulses=%0d len=%0d required 1 pulse of %0d",
                     rstLenQ.size() - nR, (rstLenQ.size() > nR) ? rstLenQ[nR] : -1, RST_CYCLES);
        end
        total++;
        if (relToCsQ.size() != nT + 1 || relToCsQ[nT] != STARTUP_CYCLES) begin
            bad++;
            $display("FAIL startup_wait: release-to-cs=%0d required %0d",
                     (relToCsQ.size() > nT) ? relToCsQ[nT] : -1, STARTUP_CYCLES);
        end
        total++;
        if (wordQ.size() != nF + 3) begin
            bad++;
            $display("FAIL frame_count: frames=%0d required 3", wordQ.size() - nF);
        end else begin
            w = wordQ[nF];
            total++;
            if ({w[15], w[14:8], w[7:0]} !== {1'b0, 7'h0A, 8'h5C}) begin
                bad++;
                $display("FAIL frame0_decode: rw=%b addr=%h data=%h required 0 0a 5c",
                         w[15], w[14:8], w[7:0]);
            end
            total++;
            if (bitsQ[nF] != 16) begin
                bad++;
                $display("FAIL frame0_bits: rising=%0d required 16", bitsQ[nF]);
            end
            total++;
            if (csLowQ[nF] != 66) begin
                bad++;
                $display("FAIL frame0_cs_low: cycles=%0d required 66", csLowQ[nF]);
            end
        end
        total++;
        if (rd_data_o !== 8'hA7) begin
            bad++;
            $display("FAIL rd_data_first: rd_data_o=%h required a7", rd_data_o);
        end
        total++;
        if ({done_o, readout_en_o, busy_o} !== 3'b110) begin
            bad++;
            $display("FAIL done_state: {done,ren,busy}=%b required 110",
                     {done_o, readout_en_o, busy_o});
        end
    endtask

    task automatic test_back_to_back();
        int nR = rstLenQ.size();
        int nF = wordQ.size();
        int nD = doneGapQ.size();
        cfg_i = {16'h0303, 16'h0202, 16'h0101};
        sdiWord = 16'h5A3C;
        pulseStart();
        total++;
        if ({done_o, readout_en_o, busy_o, ifc.adc_reset_n} !== 4'b0010) begin
            bad++;
            $display("FAIL restart_entry: {done,ren,busy,rstn}=%b required 0010",
                     {done_o, readout_en_o, busy_o, ifc.adc_reset_n});
        end
        repeat (60) @(negedge clk);
        pulseStart();
        waitDone(600);
        total++;
        if (rstLenQ.size() != nR + 1) begin
            bad++;
            $display("FAIL busy_start_ignored: reset pulses=%0d required 1", rstLenQ.size() - nR);
        end
        total++;
        if (wordQ.size() != nF + 3) begin
            bad++;
            $display("FAIL frame_count_b2b: frames=%0d required 3", wordQ.size() - nF);
        end else begin
            total++;
            if ({wordQ[nF], wordQ[nF+1], wordQ[nF+2]} !== {16'h0101, 16'h0202, 16'h0303}) begin
                bad++;
                $display("FAIL frame_order: got %h %h %h required 0101 0202 0303",
                         wordQ[nF], wordQ[nF+1], wordQ[nF+2]);
            end
            total++;
            if (gapQ[nF+1] < CS_GAP || gapQ[nF+2] < CS_GAP) begin
                bad++;
                $display("FAIL cs_gap: gaps=%0d,%0d required >=%0d", gapQ[nF+1], gapQ[nF+2], CS_GAP);
            end
            total++;
            if (csLowQ[nF+2] != 66) begin
                bad++;
                $display("FAIL frame2_cs_low: cycles=%0d required 66", csLowQ[nF+2]);
            end
        end
        total++;
        if (doneGapQ.size() != nD + 1 || doneGapQ[nD] != CS_GAP) begin
            bad++;
            $display("FAIL done_after_gap: last-cs-rise-to-done=%0d required %0d",
                     (doneGapQ.size() > nD) ? doneGapQ[nD] : -1, CS_GAP);
        end
        total++;
        if (rd_data_o !== 8'h3C) begin
            bad++;
            $display("FAIL rd_data_b2b: rd_data_o=%h required 3c", rd_data_o);
        end
        total++;
        if (violations != 0) begin
            bad++;
            $display("FAIL pin_rules: violations=%0d required 0", violations);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        int nG;
        sdiWord = 16'hFFFF;
        pulseStart();
        while (!(ifc.cs_n === 1'b0 && ifc.sclk === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ifc.cs_n !== 1'b0) begin
            bad++;
            $display("FAIL shift_reach: cs_n=%b required 0 within 200 cycles", ifc.cs_n);
        end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ifc.cs_n, ifc.sclk, busy_o, ifc.adc_reset_n, ifc.sdo} !== 5'b11010) begin
            bad++;
            $display("FAIL async_abort: {cs_n,sclk,busy,rstn,sdo}=%b required 11010",
                     {ifc.cs_n, ifc.sclk, busy_o, ifc.adc_reset_n, ifc.sdo});
        end
        total++;
        if ({rd_data_o, done_o} !== 9'h000) begin
            bad++;
            $display("FAIL async_status: rd=%h done=%b required 00 0", rd_data_o, done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        nG = gapQ.size();
        repeat (60) @(negedge clk);
        total++;
        if (busy_o !== 1'b0 || gapQ.size() != nG) begin
            bad++;
            $display("FAIL no_resume: busy=%b new frames=%0d required 0 0", busy_o, gapQ.size() - nG);
        end
        sdiWord = 16'h0081;
        pulseStart();
        waitDone(600);
        total++;
        if (rd_data_o !== 8'h81) begin
            bad++;
            $display("FAIL rerun_after_reset: rd_data_o=%h required 81", rd_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_sequence();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
